// File: rtl/mem_stage_param.sv
// MEM stage of the 5-stage MIPS pipeline: data memory, byte/half/word load-store,
// branch resolution, MEM/WB register, misalignment flag and a registered debug read port.
module mem_stage_param #(
  parameter int N_BITS     = 32,
  parameter int N_BITS_REG = 5,
  parameter int MEM_DEPTH  = 256,
  parameter int ADDR_W     = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic                  i_branch,
  input  logic                  i_branchNot,
  input  logic                  i_ceroSignal,
  input  logic [N_BITS-1:0]     i_pcBranch,
  input  logic                  i_memRead,
  input  logic                  i_memWrite,
  input  logic [1:0]            i_size,
  input  logic                  i_unsigned,
  input  logic                  i_memToReg,
  input  logic                  i_regWrite,
  input  logic [N_BITS-1:0]     i_aluResult,
  input  logic [N_BITS-1:0]     i_writeData,
  input  logic [N_BITS_REG-1:0] i_writeReg,
  input  logic [ADDR_W-1:0]     i_dbgAddr,
  output logic                  o_pcSrc,
  output logic [N_BITS-1:0]     o_pcBranch,
  output logic [N_BITS-1:0]     o_readData,
  output logic [N_BITS-1:0]     o_aluResult,
  output logic [N_BITS_REG-1:0] o_writeReg,
  output logic                  o_memToReg,
  output logic                  o_regWrite,
  output logic                  o_misaligned,
  output logic [N_BITS-1:0]     o_dbgData
);

  logic [N_BITS-1:0]     mem_q [MEM_DEPTH];

  logic [ADDR_W-1:0]     word_idx;
  logic [1:0]            lane;
  logic                  is_byte, is_half, is_word;
  logic                  misaligned;
  logic                  st_en;
  logic [N_BITS-1:0]     rd_word;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [N_BITS-1:0]     ld_ext;
  logic [31:0]           st_lanes;
  logic [3:0]            byte_en;
  logic [N_BITS-1:0]     wr_word;

  logic [N_BITS-1:0]     read_data_q, read_data_d;
  logic [N_BITS-1:0]     alu_result_q, alu_result_d;
  logic [N_BITS_REG-1:0] write_reg_q, write_reg_d;
  logic                  mem_to_reg_q, mem_to_reg_d;
  logic                  reg_write_q, reg_write_d;
  logic                  misaligned_q, misaligned_d;
  logic [N_BITS-1:0]     dbg_data_q;

  // Address bits above the memory span are ignored, so accesses wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^i_aluResult[N_BITS-1:ADDR_W+2];

  assign word_idx = i_aluResult[ADDR_W+1:2];
  assign lane     = i_aluResult[1:0];
  assign is_byte  = (i_size == 2'b00);
  assign is_half  = (i_size == 2'b01);
  assign is_word  = i_size[1];

  // Only an actual memory access can be misaligned.
  assign misaligned = (i_memRead | i_memWrite) &
                      ((is_half & lane[0]) | (is_word & (lane != 2'b00)));
  assign st_en      = i_valid & i_memWrite & ~misaligned;

  assign o_pcSrc    = i_valid & i_branch & (i_ceroSignal ^ i_branchNot);
  assign o_pcBranch = i_pcBranch;

  assign rd_word = mem_q[word_idx];

  always_comb begin
    ld_byte = rd_word[7:0];
    case (lane)
      2'b00:   ld_byte = rd_word[7:0];
      2'b01:   ld_byte = rd_word[15:8];
      2'b10:   ld_byte = rd_word[23:16];
      default: ld_byte = rd_word[31:24];
    endcase
    ld_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

    ld_ext = rd_word;
    if (is_byte)
      ld_ext = i_unsigned ? {{(N_BITS-8){1'b0}}, ld_byte}
                          : {{(N_BITS-8){ld_byte[7]}}, ld_byte};
    else if (is_half)
      ld_ext = i_unsigned ? {{(N_BITS-16){1'b0}}, ld_half}
                          : {{(N_BITS-16){ld_half[15]}}, ld_half};
  end

  // Store data is replicated across lanes; byte_en picks which lanes land.
  always_comb begin
    st_lanes = i_writeData[31:0];
    byte_en  = 4'b1111;
    if (is_byte) begin
      st_lanes = {4{i_writeData[7:0]}};
      byte_en  = 4'b0001 << lane;
    end else if (is_half) begin
      st_lanes = {2{i_writeData[15:0]}};
      byte_en  = lane[1] ? 4'b1100 : 4'b0011;
    end

    wr_word = rd_word;
    if (is_word) begin
      wr_word = i_writeData;
    end else begin
      for (int b = 0; b < 4; b++)
        if (byte_en[b]) wr_word[8*b +: 8] = st_lanes[8*b +: 8];
    end
  end

  always_ff @(posedge i_clk) begin
    if (st_en) mem_q[word_idx] <= wr_word;
  end

  always_comb begin
    read_data_d  = read_data_q;
    alu_result_d = alu_result_q;
    write_reg_d  = write_reg_q;
    mem_to_reg_d = mem_to_reg_q;
    reg_write_d  = reg_write_q;
    misaligned_d = misaligned_q;
    if (i_valid) begin
      read_data_d  = (i_memRead & ~misaligned) ? ld_ext : '0;
      alu_result_d = i_aluResult;
      write_reg_d  = i_writeReg;
      mem_to_reg_d = i_memToReg;
      reg_write_d  = i_regWrite & ~misaligned;
      misaligned_d = misaligned;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      read_data_q  <= '0;
      alu_result_q <= '0;
      write_reg_q  <= '0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      misaligned_q <= 1'b0;
      dbg_data_q   <= '0;
    end else begin
      read_data_q  <= read_data_d;
      alu_result_q <= alu_result_d;
      write_reg_q  <= write_reg_d;
      mem_to_reg_q <= mem_to_reg_d;
      reg_write_q  <= reg_write_d;
      misaligned_q <= misaligned_d;
      dbg_data_q   <= mem_q[i_dbgAddr];
    end
  end

  assign o_readData   = read_data_q;
  assign o_aluResult  = alu_result_q;
  assign o_writeReg   = write_reg_q;
  assign o_memToReg   = mem_to_reg_q;
  assign o_regWrite   = reg_write_q;
  assign o_misaligned = misaligned_q;
  assign o_dbgData    = dbg_data_q;

endmodule

// File: tb/tb_mem_stage_param.sv
// Bench for mem_stage_param: byte-array memory model, directed cases and random traffic.
module tb_mem_stage_param;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_valid, i_branch, i_branchNot, i_ceroSignal;
  logic [31:0] i_pcBranch;
  logic        i_memRead, i_memWrite;
  logic [1:0]  i_size;
  logic        i_unsigned, i_memToReg, i_regWrite;
  logic [31:0] i_aluResult, i_writeData;
  logic [4:0]  i_writeReg;
  logic [7:0]  i_dbgAddr;
  logic        o_pcSrc;
  logic [31:0] o_pcBranch, o_readData, o_aluResult;
  logic [4:0]  o_writeReg;
  logic        o_memToReg, o_regWrite, o_misaligned;
  logic [31:0] o_dbgData;

  mem_stage_param dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_branch(i_branch),
    .i_branchNot(i_branchNot), .i_ceroSignal(i_ceroSignal), .i_pcBranch(i_pcBranch),
    .i_memRead(i_memRead), .i_memWrite(i_memWrite), .i_size(i_size),
    .i_unsigned(i_unsigned), .i_memToReg(i_memToReg), .i_regWrite(i_regWrite),
    .i_aluResult(i_aluResult), .i_writeData(i_writeData), .i_writeReg(i_writeReg),
    .i_dbgAddr(i_dbgAddr), .o_pcSrc(o_pcSrc), .o_pcBranch(o_pcBranch),
    .o_readData(o_readData), .o_aluResult(o_aluResult), .o_writeReg(o_writeReg),
    .o_memToReg(o_memToReg), .o_regWrite(o_regWrite), .o_misaligned(o_misaligned),
    .o_dbgData(o_dbgData)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: plain byte-addressed little-endian memory of 1024 bytes.
  logic [7:0]  ref_bytes [1024];
  logic [31:0] e_rd, e_alu, e_dbg;
  logic [4:0]  e_wr;
  logic        e_m2r, e_rw, e_mis;
  logic        chk_dbg;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_word(input int byte_addr);
    logic [31:0] w = '0;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = ref_bytes[(byte_addr + k) % 1024];
    return w;
  endfunction

  task automatic check_regs();
    check("readData",   o_readData,   e_rd);
    check("aluResult",  o_aluResult,  e_alu);
    check("writeReg",   o_writeReg,   e_wr);
    check("memToReg",   o_memToReg,   e_m2r);
    check("regWrite",   o_regWrite,   e_rw);
    check("misaligned", o_misaligned, e_mis);
    if (chk_dbg) check("dbgData", o_dbgData, e_dbg);
  endtask

  // Inputs are already applied; predict, clock once, compare.
  task automatic step();
    int          a, nb;
    logic        mis;
    logic [31:0] v, dbg_next;
    #1;
    check("pcSrc", o_pcSrc, {31'b0, i_valid & i_branch & (i_ceroSignal ^ i_branchNot)});
    check("pcBranch", o_pcBranch, i_pcBranch);
    a   = int'(i_aluResult % 1024);
    nb  = (i_size == 2'b00) ? 1 : (i_size == 2'b01) ? 2 : 4;
    mis = (i_memRead || i_memWrite) && (a % nb != 0);
    v   = '0;
    for (int k = 0; k < nb; k++) v[8*k +: 8] = ref_bytes[a + k];
    if (!i_unsigned && nb == 1 && v[7])  v = v | 32'hFFFF_FF00;
    if (!i_unsigned && nb == 2 && v[15]) v = v | 32'hFFFF_0000;
    dbg_next = ref_word(int'(i_dbgAddr) * 4);
    @(posedge i_clk);
    #1;
    if (i_valid) begin
      e_rd  = (i_memRead && !mis) ? v : 32'h0;
      e_alu = i_aluResult;
      e_wr  = i_writeReg;
      e_m2r = i_memToReg;
      e_rw  = i_regWrite && !mis;
      e_mis = mis;
      if (i_memWrite && !mis)
        for (int k = 0; k < nb; k++) ref_bytes[a + k] = i_writeData[8*k +: 8];
    end
    e_dbg = dbg_next;
    check_regs();
  endtask

  task automatic op(input logic mr, input logic mw, input logic [1:0] sz, input logic uns,
                    input logic [31:0] addr, input logic [31:0] data);
    i_valid = 1'b1; i_branch = 1'b0;
    i_memRead = mr; i_memWrite = mw; i_size = sz; i_unsigned = uns;
    i_memToReg = mr; i_regWrite = mr;
    i_aluResult = addr; i_writeData = data;
    i_writeReg = 5'($urandom);
    step();
  endtask

  initial begin
    i_reset = 1'b0; i_valid = 1'b0; i_branch = 1'b0; i_branchNot = 1'b0;
    i_ceroSignal = 1'b0; i_pcBranch = '0; i_memRead = 1'b0; i_memWrite = 1'b0;
    i_size = 2'b10; i_unsigned = 1'b0; i_memToReg = 1'b0; i_regWrite = 1'b0;
    i_aluResult = '0; i_writeData = '0; i_writeReg = '0; i_dbgAddr = '0;
    for (int i = 0; i < 1024; i++) ref_bytes[i] = '0;
    e_rd = '0; e_alu = '0; e_wr = '0; e_m2r = 1'b0; e_rw = 1'b0; e_mis = 1'b0; e_dbg = '0;
    chk_dbg = 1'b1;

    repeat (3) @(posedge i_clk);
    #1;
    check_regs();
    #3 i_reset = 1'b1;

    // Fill memory so every later read has a known value.
    chk_dbg = 1'b0;
    for (int w = 0; w < 256; w++) op(1'b0, 1'b1, 2'b10, 1'b0, 32'(w * 4), $urandom);
    chk_dbg = 1'b1;

    for (int n = 0; n < 600; n++) begin
      i_valid      = ($urandom_range(0, 9) != 0);
      i_branch     = 1'($urandom);
      i_branchNot  = 1'($urandom);
      i_ceroSignal = 1'($urandom);
      i_pcBranch   = $urandom;
      i_memRead    = 1'($urandom);
      i_memWrite   = ($urandom_range(0, 2) == 0);
      i_size       = 2'($urandom);
      i_unsigned   = 1'($urandom);
      i_memToReg   = 1'($urandom);
      i_regWrite   = 1'($urandom);
      i_aluResult  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
      i_writeData  = $urandom;
      i_writeReg   = 5'($urandom);
      i_dbgAddr    = 8'($urandom_range(0, 15));
      step();
    end

    // Directed: SW then LW, result one cycle later.
    i_dbgAddr = 8'd4;
    op(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344);
    op(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("lw_const", o_readData, 32'h1122_3344);
    check("lw_regwr", {31'b0, o_regWrite}, 32'h1);

    // Stalled store: no write, MEM/WB holds.
    i_valid = 1'b0; i_memWrite = 1'b1; i_memRead = 1'b0; i_writeData = 32'hDEAD_BEEF;
    step();
    check("stall_hold", o_readData, 32'h1122_3344);
    op(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("stall_nowr", o_readData, 32'h1122_3344);

    // Byte store and signed/unsigned byte loads.
    op(1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AB);
    op(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("sb_word", o_readData, 32'h1122_AB44);
    op(1'b1, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    check("lb", o_readData, 32'hFFFF_FFAB);
    op(1'b1, 1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
    check("lbu", o_readData, 32'h0000_00AB);

    // Halfword loads on a different word; misaligned SH leaves memory alone.
    op(1'b0, 1'b1, 2'b11, 1'b0, 32'h30, 32'h8000_1234);
    op(1'b1, 1'b0, 2'b01, 1'b0, 32'h32, 32'h0);
    check("lh", o_readData, 32'hFFFF_8000);
    op(1'b1, 1'b0, 2'b01, 1'b1, 32'h32, 32'h0);
    check("lhu", o_readData, 32'h0000_8000);
    op(1'b0, 1'b1, 2'b01, 1'b0, 32'h33, 32'hFFFF_FFFF);
    check("sh_mis", {31'b0, o_misaligned}, 32'h1);
    op(1'b1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
    check("sh_nowr", o_readData, 32'h8000_1234);

    // Branch resolution.
    i_memRead = 1'b0; i_memWrite = 1'b0; i_branch = 1'b1; i_ceroSignal = 1'b1;
    i_valid = 1'b1; i_branchNot = 1'b0; #1;
    check("beq_taken", {31'b0, o_pcSrc}, 32'h1);
    i_branchNot = 1'b1; #1;
    check("bne_zero", {31'b0, o_pcSrc}, 32'h0);
    i_branchNot = 1'b0; i_valid = 1'b0; #1;
    check("br_stall", {31'b0, o_pcSrc}, 32'h0);
    step();

    // Reset in the middle of a load cycle.
    i_valid = 1'b1; i_branch = 1'b0; i_memRead = 1'b1; i_size = 2'b10;
    i_aluResult = 32'h10; i_regWrite = 1'b1; i_memToReg = 1'b1;
    @(posedge i_clk);
    #2 i_reset = 1'b0;
    #1;
    e_rd = '0; e_alu = '0; e_wr = '0; e_m2r = 1'b0; e_rw = 1'b0; e_mis = 1'b0; e_dbg = '0;
    check_regs();
    #1 i_reset = 1'b1;
    i_valid = 1'b0; i_dbgAddr = 8'd4;
    step();
    check("dbg_after_rst", o_dbgData, 32'h1122_AB44);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
